dmem_access_ctrl: RTL and testbench
===================================

Name: dmem_access_ctrl

Overview:
- Memory-stage data-access controller: turns the M-stage load/store (aluout address, 8-bit alucontrol code, store data) into a request/address-ok/data-ok handshake on the data bus.
- Generates byte enables and replicated store data; detects misaligned addresses.
- Stalls the pipeline until the access completes.
- Delivers the raw 32-bit read word to the W-stage register; byte/half extraction happens downstream in W using the same big-endian lane convention (address offset 00 = bits 31:24).

Parameters:
- ADDR_W, 32, address width of aluoutM and data_addr.
- DATA_W, 32, data-bus width; only 32 is supported.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- memenM  in  1  M-stage instruction is a load or store.
- alucontrolM  in  8  operation code from defines2.vh: LB/LBU/LH/LHU/LW/SB/SH/SW _CONTROL.
- aluoutM  in  32  effective address.
- writedataM  in  32  store source register value.
- flushM  in  1  exception/flush of the M-stage instruction.
- advance  in  1  pipeline moves M->W this cycle (global stall low).
- data_req  out  1  bus request.
- data_wr  out  1  1 = write.
- data_be  out  4  byte enables; bit3 = bits 31:24.
- data_addr  out  32  word-aligned address.
- data_wdata  out  32  store data.
- data_addr_ok  in  1  request accepted.
- data_data_ok  in  1  read data valid / write complete.
- data_rdata  in  32  read word.
- readdataM  out  32  captured read word, registered.
- stallM  out  1  M-stage stall request, combinational.
- laddrerrM  out  1  load address error, combinational.
- saddrerrM  out  1  store address error, combinational.
- badvaddrM  out  32  faulting address; equals aluoutM.

Behaviour:
- Reset: state=IDLE. data_req, data_wr, data_be, data_addr, data_wdata and readdataM are all 0. Reset mid-transaction drops to IDLE; the bus slave shares rst.
- Misalignment:
  - LH/LHU/SH with aluoutM[0]!=0 is an error.
  - LW/SW with aluoutM[1:0]!=0 is an error.
  - Byte accesses never fault.
  - laddrerrM/saddrerrM are asserted only while memenM is high. A faulting access issues no request and keeps stallM=0.
- Store lanes:
  - SB: wdata = {4{wd[7:0]}}; be per offset: 00->1000, 01->0100, 10->0010, 11->0001.
  - SH: wdata = {2{wd[15:0]}}; be: 00->1100, 10->0011.
  - SW: wdata = wd; be = 1111.
  - Loads: wr=0, be=0000.
- data_addr = {aluoutM[31:2],2'b00}.
- FSM states: IDLE, REQ, WAIT, DONE, ABORT.
  - IDLE: when memenM & ~err & ~flushM, register all bus outputs, set data_req=1 and go to REQ.
  - REQ: hold every bus output stable until data_addr_ok.
    - addr_ok & ~data_ok: drop data_req, go to WAIT.
    - addr_ok & data_ok in the same cycle: capture data_rdata (loads) and go to DONE.
    - flushM before addr_ok: drop data_req, go to IDLE.
  - WAIT: on data_ok, load -> readdataM <= data_rdata; store -> readdataM unchanged; go to DONE. flushM in WAIT -> ABORT.
  - ABORT: wait for data_ok, discard the data, go to IDLE. No stall is requested.
  - DONE: result held; advance -> IDLE. flushM -> IDLE.
- stallM = memenM & ~err & ~flushM & (state != DONE). First-request latency: 1 cycle to REQ plus bus latency; minimum 3 cycles of stall with addr_ok in REQ and data_ok one cycle later.
- Back-to-back memory instructions: DONE + advance -> IDLE. The next request issues one cycle later; no bus pipelining.
- A new request is never issued while in ABORT, so stallM stays high for a following memory instruction until ABORT exits.

Test Plan:
- LW at 0x100, addr_ok in cycle 1, data_ok in cycle 2 with rdata 0xDEADBEEF -> data_addr 0x100, be 0000, wr 0; readdataM = 0xDEADBEEF; stallM low once DONE is reached.
- SB at 0x203 with wd = 0x12345678 -> data_addr 0x200, be 0001, wdata 0x78787878, wr 1. SH at 0x202 -> be 0011, wdata 0x56785678.
- LH at 0x101 -> laddrerrM=1, badvaddrM=0x101, data_req never asserted, stallM=0. SW at 0x102 -> saddrerrM=1, no request.
- addr_ok and data_ok in the same cycle with rdata 0xA5A5A5A5 -> REQ goes directly to DONE; readdataM=0xA5A5A5A5.
- flushM asserted in WAIT, data_ok 3 cycles later with rdata 0x11111111 -> ABORT; readdataM keeps its old value; IDLE after data_ok.
- rst asserted while in REQ -> next cycle state IDLE, data_req=0, readdataM=0.

Source files
------------

// File: rtl/dmem_access_ctrl.sv
// ============================================================================
// dmem_access_ctrl
// ----------------------------------------------------------------------------
// Memory-stage data-access controller. Turns the M-stage load/store (effective
// address, 8-bit ALU control code, store data) into a request / address-ok /
// data-ok handshake on the data bus. It builds byte enables and replicated
// store data, flags misaligned addresses, and holds the pipeline until the bus
// access has completed. The raw 32-bit read word goes to the W stage; byte and
// half extraction happens downstream with the same big-endian lane convention
// (address offset 00 selects bits 31:24).
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   memenM              M-stage instruction is a load or store
//   alucontrolM         operation code (LB/LBU/LH/LHU/LW/SB/SH/SW)
//   aluoutM             effective address
//   writedataM          store source register value
//   flushM              exception/flush of the M-stage instruction
//   advance             pipeline moves M->W this cycle
//   data_req/wr/be/addr/wdata   registered bus request outputs
//   data_addr_ok        request accepted by the slave
//   data_data_ok        read data valid / write complete
//   data_rdata          read word from the slave
//   readdataM           captured read word (registered)
//   stallM              M-stage stall request (combinational)
//   laddrerrM/saddrerrM load/store address error (combinational)
//   badvaddrM           faulting address (always aluoutM)
//
// Only DATA_W = 32 is supported; the lane replication assumes four bytes.
// ============================================================================
module dmem_access_ctrl #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              memenM,
   input  logic [7:0]        alucontrolM,
   input  logic [ADDR_W-1:0] aluoutM,
   input  logic [DATA_W-1:0] writedataM,
   input  logic              flushM,
   input  logic              advance,
   output logic              data_req,
   output logic              data_wr,
   output logic [3:0]        data_be,
   output logic [ADDR_W-1:0] data_addr,
   output logic [DATA_W-1:0] data_wdata,
   input  logic              data_addr_ok,
   input  logic              data_data_ok,
   input  logic [DATA_W-1:0] data_rdata,
   output logic [DATA_W-1:0] readdataM,
   output logic              stallM,
   output logic              laddrerrM,
   output logic              saddrerrM,
   output logic [ADDR_W-1:0] badvaddrM
);

   localparam logic [7:0] LB_CONTROL  = 8'b1110_0000;
   localparam logic [7:0] LBU_CONTROL = 8'b1110_0100;
   localparam logic [7:0] LH_CONTROL  = 8'b1110_0001;
   localparam logic [7:0] LHU_CONTROL = 8'b1110_0101;
   localparam logic [7:0] LW_CONTROL  = 8'b1110_0011;
   localparam logic [7:0] SB_CONTROL  = 8'b1110_1000;
   localparam logic [7:0] SH_CONTROL  = 8'b1110_1001;
   localparam logic [7:0] SW_CONTROL  = 8'b1110_1011;

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      WAIT,
      DONE,
      ABORT
   } stateT;

   stateT             state;
   logic              isStore;
   logic              isHalf;
   logic              isByte;
   logic              misaligned;
   logic              issueOk;
   logic [1:0]        offset;
   logic [3:0]        laneBe;
   logic [DATA_W-1:0] laneData;

   assign offset = aluoutM[1:0];

   // Decode the access size and direction from the ALU control code, then
   // work out alignment, byte enables and the replicated store word. Any code
   // that is not a recognised store is handled as a word load, so a stray
   // memenM can never leave the pipeline waiting for a request that never
   // goes out. Loads never drive byte enables.
   always_comb begin
      isStore    = 1'b0;
      isHalf     = 1'b0;
      isByte     = 1'b0;
      misaligned = 1'b0;
      laneBe     = 4'b0000;
      laneData   = writedataM;
      case (alucontrolM)
         LB_CONTROL, LBU_CONTROL: isByte = 1'b1;
         LH_CONTROL, LHU_CONTROL: isHalf = 1'b1;
         LW_CONTROL:              isHalf = 1'b0;
         SB_CONTROL: begin
            isStore = 1'b1;
            isByte  = 1'b1;
         end
         SH_CONTROL: begin
            isStore = 1'b1;
            isHalf  = 1'b1;
         end
         SW_CONTROL:              isStore = 1'b1;
         default:                 isStore = 1'b0;
      endcase

      if (isByte) begin
         misaligned = 1'b0;
         laneData   = {4{writedataM[7:0]}};
         if (isStore) begin
            case (offset)
               2'b00:   laneBe = 4'b1000;
               2'b01:   laneBe = 4'b0100;
               2'b10:   laneBe = 4'b0010;
               default: laneBe = 4'b0001;
            endcase
         end
      end else if (isHalf) begin
         misaligned = offset[0];
         laneData   = {2{writedataM[15:0]}};
         if (isStore) begin
            laneBe = offset[1] ? 4'b0011 : 4'b1100;
         end
      end else begin
         misaligned = (offset != 2'b00);
         if (isStore) begin
            laneBe = 4'b1111;
         end
      end
   end

   // Address errors only matter while a memory instruction actually sits in
   // M. A faulting access never requests the bus and never stalls, so the
   // exception logic can take it straight away. Once the access is in DONE
   // the result is held and the stall lifts, letting the pipeline advance.
   assign issueOk   = memenM & ~misaligned & ~flushM;
   assign laddrerrM = memenM & misaligned & ~isStore;
   assign saddrerrM = memenM & misaligned & isStore;
   assign badvaddrM = aluoutM;
   assign stallM    = issueOk & (state != DONE);

   // Bus handshake state machine. All bus outputs are registered when the
   // request is launched and stay frozen until the slave accepts it. A flush
   // before acceptance simply withdraws the request; a flush after acceptance
   // must still wait for the slave's data_ok (ABORT) because the slave will
   // answer regardless, and that answer must not be mistaken for the next
   // instruction's data. readdataM is only updated by completing loads.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         data_req   <= 1'b0;
         data_wr    <= 1'b0;
         data_be    <= 4'b0000;
         data_addr  <= '0;
         data_wdata <= '0;
         readdataM  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (issueOk) begin
                  data_req   <= 1'b1;
                  data_wr    <= isStore;
                  data_be    <= laneBe;
                  data_addr  <= {aluoutM[ADDR_W-1:2], 2'b00};
                  data_wdata <= laneData;
                  state      <= REQ;
               end
            end
            REQ: begin
               if (data_addr_ok) begin
                  data_req <= 1'b0;
                  if (data_data_ok) begin
                     if (!data_wr) begin
                        readdataM <= data_rdata;
                     end
                     state <= DONE;
                  end else if (flushM) begin
                     state <= ABORT;
                  end else begin
                     state <= WAIT;
                  end
               end else if (flushM) begin
                  data_req <= 1'b0;
                  state    <= IDLE;
               end
            end
            WAIT: begin
               if (data_data_ok) begin
                  if (flushM) begin
                     state <= IDLE;
                  end else begin
                     if (!data_wr) begin
                        readdataM <= data_rdata;
                     end
                     state <= DONE;
                  end
               end else if (flushM) begin
                  state <= ABORT;
               end
            end
            ABORT: begin
               if (data_data_ok) begin
                  state <= IDLE;
               end
            end
            DONE: begin
               if (advance || flushM) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// ============================================================================
// tb_dmem_access_ctrl
// ----------------------------------------------------------------------------
// Self-checking bench for dmem_access_ctrl. The bench plays both the pipeline
// (memenM/advance/flushM) and the bus slave (addr_ok/data_ok/rdata). Expected
// lanes, enables and fault flags come from a small arithmetic model of the
// access rules; expected read data is tracked in expRead.
// ============================================================================
module tb_dmem_access_ctrl;

   localparam logic [7:0] LB  = 8'b1110_0000;
   localparam logic [7:0] LBU = 8'b1110_0100;
   localparam logic [7:0] LH  = 8'b1110_0001;
   localparam logic [7:0] LHU = 8'b1110_0101;
   localparam logic [7:0] LW  = 8'b1110_0011;
   localparam logic [7:0] SB  = 8'b1110_1000;
   localparam logic [7:0] SH  = 8'b1110_1001;
   localparam logic [7:0] SW  = 8'b1110_1011;

   logic        clk = 1'b0;
   logic        rst;
   logic        memenM;
   logic [7:0]  alucontrolM;
   logic [31:0] aluoutM;
   logic [31:0] writedataM;
   logic        flushM;
   logic        advance;
   logic        data_req;
   logic        data_wr;
   logic [3:0]  data_be;
   logic [31:0] data_addr;
   logic [31:0] data_wdata;
   logic        data_addr_ok;
   logic        data_data_ok;
   logic [31:0] data_rdata;
   logic [31:0] readdataM;
   logic        stallM;
   logic        laddrerrM;
   logic        saddrerrM;
   logic [31:0] badvaddrM;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] expRead;

   dmem_access_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk          (clk),
      .rst          (rst),
      .memenM       (memenM),
      .alucontrolM  (alucontrolM),
      .aluoutM      (aluoutM),
      .writedataM   (writedataM),
      .flushM       (flushM),
      .advance      (advance),
      .data_req     (data_req),
      .data_wr      (data_wr),
      .data_be      (data_be),
      .data_addr    (data_addr),
      .data_wdata   (data_wdata),
      .data_addr_ok (data_addr_ok),
      .data_data_ok (data_data_ok),
      .data_rdata   (data_rdata),
      .readdataM    (readdataM),
      .stallM       (stallM),
      .laddrerrM    (laddrerrM),
      .saddrerrM    (saddrerrM),
      .badvaddrM    (badvaddrM)
   );

   // Free-running 100 MHz-style clock.
   always #5 clk = ~clk;

   // Present one M-stage instruction to the controller.
   task automatic applyStimulus(input logic en, input logic [7:0] op,
                                input logic [31:0] addr, input logic [31:0] wd);
      memenM      = en;
      alucontrolM = op;
      aluoutM     = addr;
      writedataM  = wd;
   endtask

   // Advance one clock; outputs are sampled 1 time unit after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Access size in bytes for an operation code.
   function automatic int opSize(input logic [7:0] op);
      if (op == LB || op == LBU || op == SB) return 1;
      if (op == LH || op == LHU || op == SH) return 2;
      return 4;
   endfunction

   function automatic bit opIsStore(input logic [7:0] op);
      return (op == SB) || (op == SH) || (op == SW);
   endfunction

   // An access faults when the address is not a multiple of its size.
   function automatic bit modelErr(input logic [7:0] op, input logic [31:0] addr);
      return (addr % opSize(op)) != 0;
   endfunction

   // Enables: a run of size bits, placed so offset 0 lands on bit 3.
   function automatic logic [3:0] modelBe(input logic [7:0] op, input logic [31:0] addr);
      int sz;
      int off;
      int mask;
      if (!opIsStore(op)) return 4'b0000;
      sz   = opSize(op);
      off  = int'(addr % 4);
      mask = (1 << sz) - 1;
      return 4'(mask << (4 - sz - off));
   endfunction

   // Store word: the low size bytes copied across all four lanes.
   function automatic logic [31:0] modelWdata(input logic [7:0] op, input logic [31:0] wd);
      case (opSize(op))
         1:       return {24'h0, wd[7:0]} * 32'h0101_0101;
         2:       return {16'h0, wd[15:0]} * 32'h0001_0001;
         default: return wd;
      endcase
   endfunction

   task automatic test_reset();
      rst          = 1'b1;
      flushM       = 1'b0;
      advance      = 1'b0;
      data_addr_ok = 1'b0;
      data_data_ok = 1'b0;
      data_rdata   = 32'h0;
      applyStimulus(1'b1, SW, 32'h0000_0040, 32'hFFFF_FFFF);
      tick();
      tick();
      checks++; if (data_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_req: got %0b want 0", data_req); end
      checks++; if (data_wr !== 1'b0) begin errors++; $display("[TB] FAIL reset_wr: got %0b want 0", data_wr); end
      checks++; if (data_be !== 4'b0000) begin errors++; $display("[TB] FAIL reset_be: got %b want 0000", data_be); end
      checks++; if (data_addr !== 32'h0) begin errors++; $display("[TB] FAIL reset_addr: got %h want 0", data_addr); end
      checks++; if (data_wdata !== 32'h0) begin errors++; $display("[TB] FAIL reset_wdata: got %h want 0", data_wdata); end
      checks++; if (readdataM !== 32'h0) begin errors++; $display("[TB] FAIL reset_rdata: got %h want 0", readdataM); end
      checks++; if (stallM !== 1'b1) begin errors++; $display("[TB] FAIL reset_stall_idle: got %0b want 1", stallM); end
      applyStimulus(1'b0, LW, 32'h0, 32'h0);
      rst     = 1'b0;
      expRead = 32'h0;
      #1;
      checks++; if (stallM !== 1'b0) begin errors++; $display("[TB] FAIL reset_stall_off: got %0b want 0", stallM); end
   endtask

   task automatic test_lw();
      int stalls = 0;
      applyStimulus(1'b1, LW, 32'h0000_0100, 32'hCAFE_0000);
      #1;
      if (stallM === 1'b1) stalls++;
      checks++; if (data_req !== 1'b0) begin errors++; $display("[TB] FAIL lw_idle_req: got %0b want 0", data_req); end
      tick();
      if (stallM === 1'b1) stalls++;
      checks++; if (data_req !== 1'b1) begin errors++; $display("[TB] FAIL lw_req: got %0b want 1", data_req); end
      checks++; if (data_addr !== 32'h100) begin errors++; $display("[TB] FAIL lw_addr: got %h want 00000100", data_addr); end
      checks++; if (data_be !== 4'b0000) begin errors++; $display("[TB] FAIL lw_be: got %b want 0000", data_be); end
      checks++; if (data_wr !== 1'b0) begin errors++; $display("[TB] FAIL lw_wr: got %0b want 0", data_wr); end
      data_addr_ok = 1'b1;
      tick();
      data_addr_ok = 1'b0;
      if (stallM === 1'b1) stalls++;
      checks++; if (data_req !== 1'b0) begin errors++; $display("[TB] FAIL lw_wait_req: got %0b want 0", data_req); end
      data_data_ok = 1'b1;
      data_rdata   = 32'hDEAD_BEEF;
      tick();
      data_data_ok = 1'b0;
      expRead      = 32'hDEAD_BEEF;
      checks++; if (stallM !== 1'b0) begin errors++; $display("[TB] FAIL lw_done_stall: got %0b want 0", stallM); end
      checks++; if (readdataM !== expRead) begin errors++; $display("[TB] FAIL lw_rdata: got %h want %h", readdataM, expRead); end
      checks++; if (stalls !== 3) begin errors++; $display("[TB] FAIL lw_stall_cycles: got %0d want 3", stalls); end
      advance = 1'b1;
      tick();
      advance = 1'b0;
      applyStimulus(1'b0, LW, 32'h0, 32'h0);
   endtask

   task automatic test_store_lanes();
      applyStimulus(1'b1, SB, 32'h0000_0203, 32'h1234_5678);
      tick();
      checks++; if (data_addr !== 32'h200) begin errors++; $display("[TB] FAIL sb_addr: got %h want 00000200", data_addr); end
      checks++; if (data_be !== 4'b0001) begin errors++; $display("[TB] FAIL sb_be: got %b want 0001", data_be); end
      checks++; if (data_wdata !== 32'h7878_7878) begin errors++; $display("[TB] FAIL sb_wdata: got %h want 78787878", data_wdata); end
      checks++; if (data_wr !== 1'b1) begin errors++; $display("[TB] FAIL sb_wr: got %0b want 1", data_wr); end
      data_addr_ok = 1'b1;
      data_data_ok = 1'b1;
      data_rdata   = 32'h0BAD_0BAD;
      tick();
      data_addr_ok = 1'b0;
      data_data_ok = 1'b0;
      checks++; if (readdataM !== expRead) begin errors++; $display("[TB] FAIL sb_keep_rdata: got %h want %h", readdataM, expRead); end
      advance = 1'b1;
      tick();
      advance = 1'b0;
      applyStimulus(1'b1, SH, 32'h0000_0202, 32'h1234_5678);
      tick();
      checks++; if (data_be !== 4'b0011) begin errors++; $display("[TB] FAIL sh_be: got %b want 0011", data_be); end
      checks++; if (data_wdata !== 32'h5678_5678) begin errors++; $display("[TB] FAIL sh_wdata: got %h want 56785678", data_wdata); end
      data_addr_ok = 1'b1;
      tick();
      data_addr_ok = 1'b0;
      data_data_ok = 1'b1;
      tick();
      data_data_ok = 1'b0;
      advance = 1'b1;
      tick();
      advance = 1'b0;
      applyStimulus(1'b0, LW, 32'h0, 32'h0);
   endtask

   task automatic test_misaligned();
      applyStimulus(1'b1, LH, 32'h0000_0101, 32'h0);
      #1;
      checks++; if (laddrerrM !== 1'b1) begin errors++; $display("[TB] FAIL lh_laddrerr: got %0b want 1", laddrerrM); end
      checks++; if (saddrerrM !== 1'b0) begin errors++; $display("[TB] FAIL lh_saddrerr: got %0b want 0", saddrerrM); end
      checks++; if (badvaddrM !== 32'h101) begin errors++; $display("[TB] FAIL lh_badvaddr: got %h want 00000101", badvaddrM); end
      checks++; if (stallM !== 1'b0) begin errors++; $display("[TB] FAIL lh_stall: got %0b want 0", stallM); end
      for (int i = 0; i < 2; i++) begin
         tick();
         checks++; if (data_req !== 1'b0) begin errors++; $display("[TB] FAIL lh_noreq: got %0b want 0", data_req); end
      end
      applyStimulus(1'b0, LH, 32'h0000_0101, 32'h0);
      #1;
      checks++; if (laddrerrM !== 1'b0) begin errors++; $display("[TB] FAIL lh_err_gated: got %0b want 0", laddrerrM); end
      applyStimulus(1'b1, SW, 32'h0000_0102, 32'h0);
      #1;
      checks++; if (saddrerrM !== 1'b1) begin errors++; $display("[TB] FAIL sw_saddrerr: got %0b want 1", saddrerrM); end
      checks++; if (laddrerrM !== 1'b0) begin errors++; $display("[TB] FAIL sw_laddrerr: got %0b want 0", laddrerrM); end
      tick();
      checks++; if (data_req !== 1'b0) begin errors++; $display("[TB] FAIL sw_noreq: got %0b want 0", data_req); end
      applyStimulus(1'b0, LW, 32'h0, 32'h0);
   endtask

   task automatic test_same_cycle();
      applyStimulus(1'b1, LW, 32'h0000_0044, 32'h0);
      tick();
      data_addr_ok = 1'b1;
      data_data_ok = 1'b1;
      data_rdata   = 32'hA5A5_A5A5;
      tick();
      data_addr_ok = 1'b0;
      data_data_ok = 1'b0;
      expRead      = 32'hA5A5_A5A5;
      checks++; if (stallM !== 1'b0) begin errors++; $display("[TB] FAIL same_stall: got %0b want 0", stallM); end
      checks++; if (readdataM !== expRead) begin errors++; $display("[TB] FAIL same_rdata: got %h want %h", readdataM, expRead); end
      checks++; if (data_req !== 1'b0) begin errors++; $display("[TB] FAIL same_req: got %0b want 0", data_req); end
      advance = 1'b1;
      tick();
      advance = 1'b0;
      applyStimulus(1'b0, LW, 32'h0, 32'h0);
   endtask

   task automatic test_flush_wait();
      applyStimulus(1'b1, LW, 32'h0000_0500, 32'h0);
      tick();
      data_addr_ok = 1'b1;
      tick();
      data_addr_ok = 1'b0;
      flushM = 1'b1;
      #1;
      checks++; if (stallM !== 1'b0) begin errors++; $display("[TB] FAIL flush_stall: got %0b want 0", stallM); end
      tick();
      flushM = 1'b0;
      applyStimulus(1'b0, LW, 32'h0, 32'h0);
      #1;
      checks++; if (stallM !== 1'b0) begin errors++; $display("[TB] FAIL abort_stall: got %0b want 0", stallM); end
      applyStimulus(1'b1, LW, 32'h0000_0600, 32'h0);
      #1;
      checks++; if (stallM !== 1'b1) begin errors++; $display("[TB] FAIL abort_next_stall: got %0b want 1", stallM); end
      tick();
      checks++; if (data_req !== 1'b0) begin errors++; $display("[TB] FAIL abort_noreq: got %0b want 0", data_req); end
      data_data_ok = 1'b1;
      data_rdata   = 32'h1111_1111;
      tick();
      data_data_ok = 1'b0;
      checks++; if (readdataM !== expRead) begin errors++; $display("[TB] FAIL abort_rdata: got %h want %h", readdataM, expRead); end
      checks++; if (data_req !== 1'b0) begin errors++; $display("[TB] FAIL abort_idle_req: got %0b want 0", data_req); end
      tick();
      checks++; if (data_req !== 1'b1) begin errors++; $display("[TB] FAIL abort_reissue: got %0b want 1", data_req); end
      checks++; if (data_addr !== 32'h600) begin errors++; $display("[TB] FAIL abort_reissue_addr: got %h want 00000600", data_addr); end
      data_addr_ok = 1'b1;
      data_data_ok = 1'b1;
      data_rdata   = 32'h2222_2222;
      tick();
      data_addr_ok = 1'b0;
      data_data_ok = 1'b0;
      expRead      = 32'h2222_2222;
      advance = 1'b1;
      tick();
      advance = 1'b0;
      applyStimulus(1'b0, LW, 32'h0, 32'h0);
   endtask

   task automatic test_reset_in_req();
      applyStimulus(1'b1, LW, 32'h0000_0300, 32'h0);
      tick();
      checks++; if (data_req !== 1'b1) begin errors++; $display("[TB] FAIL rstreq_pre: got %0b want 1", data_req); end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      expRead = 32'h0;
      checks++; if (data_req !== 1'b0) begin errors++; $display("[TB] FAIL rstreq_req: got %0b want 0", data_req); end
      checks++; if (readdataM !== 32'h0) begin errors++; $display("[TB] FAIL rstreq_rdata: got %h want 0", readdataM); end
      applyStimulus(1'b0, LW, 32'h0, 32'h0);
      tick();
   endtask

   task automatic test_back_to_back();
      applyStimulus(1'b1, LW, 32'h0000_0700, 32'h0);
      tick();
      data_addr_ok = 1'b1;
      data_data_ok = 1'b1;
      data_rdata   = 32'h3333_3333;
      tick();
      data_addr_ok = 1'b0;
      data_data_ok = 1'b0;
      expRead      = 32'h3333_3333;
      advance = 1'b1;
      tick();
      advance = 1'b0;
      applyStimulus(1'b1, SW, 32'h0000_0804, 32'h4444_5555);
      #1;
      checks++; if (data_req !== 1'b0) begin errors++; $display("[TB] FAIL b2b_gap_req: got %0b want 0", data_req); end
      checks++; if (stallM !== 1'b1) begin errors++; $display("[TB] FAIL b2b_gap_stall: got %0b want 1", stallM); end
      tick();
      checks++; if (data_req !== 1'b1) begin errors++; $display("[TB] FAIL b2b_req: got %0b want 1", data_req); end
      checks++; if (data_addr !== 32'h804) begin errors++; $display("[TB] FAIL b2b_addr: got %h want 00000804", data_addr); end
      data_addr_ok = 1'b1;
      data_data_ok = 1'b1;
      tick();
      data_addr_ok = 1'b0;
      data_data_ok = 1'b0;
      checks++; if (readdataM !== expRead) begin errors++; $display("[TB] FAIL b2b_rdata: got %h want %h", readdataM, expRead); end
      advance = 1'b1;
      tick();
      advance = 1'b0;
      applyStimulus(1'b0, LW, 32'h0, 32'h0);
   endtask

   task automatic test_random();
      logic [7:0]  ops [8] = '{LB, LBU, LH, LHU, LW, SB, SH, SW};
      logic [7:0]  op;
      logic [31:0] addr;
      logic [31:0] wd;
      logic [31:0] rd;
      int          aLat;
      int          dLat;
      int          hold;
      for (int n = 0; n < 60; n++) begin
         op   = ops[$urandom_range(0, 7)];
         addr = $urandom;
         if ($urandom_range(0, 1) == 1) addr[1:0] = 2'b00;
         wd   = $urandom;
         rd   = $urandom;
         aLat = $urandom_range(0, 2);
         dLat = $urandom_range(0, 3);
         hold = $urandom_range(0, 2);
         applyStimulus(1'b1, op, addr, wd);
         #1;
         if (modelErr(op, addr)) begin
            checks++; if (laddrerrM !== !opIsStore(op)) begin errors++; $display("[TB] FAIL rnd_laddrerr: got %0b want %0b", laddrerrM, !opIsStore(op)); end
            checks++; if (saddrerrM !== opIsStore(op)) begin errors++; $display("[TB] FAIL rnd_saddrerr: got %0b want %0b", saddrerrM, opIsStore(op)); end
            checks++; if (badvaddrM !== addr) begin errors++; $display("[TB] FAIL rnd_badvaddr: got %h want %h", badvaddrM, addr); end
            checks++; if (stallM !== 1'b0) begin errors++; $display("[TB] FAIL rnd_err_stall: got %0b want 0", stallM); end
            tick();
            checks++; if (data_req !== 1'b0) begin errors++; $display("[TB] FAIL rnd_err_noreq: got %0b want 0", data_req); end
            applyStimulus(1'b0, LW, 32'h0, 32'h0);
            continue;
         end
         checks++; if ((laddrerrM | saddrerrM) !== 1'b0) begin errors++; $display("[TB] FAIL rnd_noerr: got %0b want 0", laddrerrM | saddrerrM); end
         checks++; if (stallM !== 1'b1) begin errors++; $display("[TB] FAIL rnd_idle_stall: got %0b want 1", stallM); end
         tick();
         for (int c = 0; c <= aLat; c++) begin
            checks++; if (data_req !== 1'b1) begin errors++; $display("[TB] FAIL rnd_req: got %0b want 1", data_req); end
            checks++; if (data_addr !== {addr[31:2], 2'b00}) begin errors++; $display("[TB] FAIL rnd_addr: got %h want %h", data_addr, {addr[31:2], 2'b00}); end
            checks++; if (data_be !== modelBe(op, addr)) begin errors++; $display("[TB] FAIL rnd_be: got %b want %b", data_be, modelBe(op, addr)); end
            checks++; if (data_wr !== opIsStore(op)) begin errors++; $display("[TB] FAIL rnd_wr: got %0b want %0b", data_wr, opIsStore(op)); end
            if (opIsStore(op)) begin
               checks++; if (data_wdata !== modelWdata(op, wd)) begin errors++; $display("[TB] FAIL rnd_wdata: got %h want %h", data_wdata, modelWdata(op, wd)); end
            end
            checks++; if (stallM !== 1'b1) begin errors++; $display("[TB] FAIL rnd_req_stall: got %0b want 1", stallM); end
            if (c == aLat) begin
               data_addr_ok = 1'b1;
               if (dLat == 0) begin
                  data_data_ok = 1'b1;
                  data_rdata   = rd;
               end
            end
            tick();
            data_addr_ok = 1'b0;
            data_data_ok = 1'b0;
         end
         for (int c = 1; c <= dLat; c++) begin
            checks++; if (data_req !== 1'b0) begin errors++; $display("[TB] FAIL rnd_wait_req: got %0b want 0", data_req); end
            checks++; if (stallM !== 1'b1) begin errors++; $display("[TB] FAIL rnd_wait_stall: got %0b want 1", stallM); end
            if (c == dLat) begin
               data_data_ok = 1'b1;
               data_rdata   = rd;
            end
            tick();
            data_data_ok = 1'b0;
         end
         if (!opIsStore(op)) expRead = rd;
         for (int c = 0; c <= hold; c++) begin
            checks++; if (stallM !== 1'b0) begin errors++; $display("[TB] FAIL rnd_done_stall: got %0b want 0", stallM); end
            checks++; if (readdataM !== expRead) begin errors++; $display("[TB] FAIL rnd_rdata: got %h want %h", readdataM, expRead); end
            if (c == hold) advance = 1'b1;
            tick();
         end
         advance = 1'b0;
         applyStimulus(1'b0, LW, 32'h0, 32'h0);
      end
   endtask

   // Run every scenario in order, then report.
   initial begin
      test_reset();
      test_lw();
      test_store_lanes();
      test_misaligned();
      test_same_cycle();
      test_flush_wait();
      test_reset_in_req();
      test_back_to_back();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
